alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, two-stage pipelined successor to the team's combinational 8-bit four-operand ALU. Keeps the same operation set, including the shared four-operand sum and the select-sum. Adds a valid/ready handshake with full backpressure, carry/borrow and zero flags, and a persistent accumulator mode. It sits between an operand-issue front end and a result consumer, and may stall on either side.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)
- ACC_EN, 1, 1 = accumulator opcodes implemented; 0 = they decode as default

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept bundle this cycle
- input_a, input_b, input_c, input_d  in  WIDTH each  operands
- opcode  in  4  operation select
- sel  in  1  operand choice for SEL_SUM
- out_valid  out  1  result bundle valid
- out_ready  in  1  consumer accepts result this cycle
- result  out  WIDTH  operation result
- zero_flag  out  1  result == 0
- carry_flag  out  1  carry (add ops) or borrow (SUB), else 0
- acc_value  out  WIDTH  current accumulator contents

## Operation
- Opcodes:
  - 0 and 7, ADD4: a+b+c+d mod 2^WIDTH; carry = any bit of the full WIDTH+2-bit sum above WIDTH-1.
  - 1, SUB: a−b mod 2^WIDTH; carry = (a<b).
  - 2, AND: a&b. 3, OR: a|b. 4, XOR: a^b.
  - 5, NOT: ~a.
  - 6, SEL_SUM: sel ? a+c : b+d; carry = carry-out of the selected WIDTH+1-bit sum.
  - 8, ACC_ADD: acc ← acc+a; result = new acc; carry = carry-out.
  - 9, ACC_CLR: acc ← 0; result = 0.
  - 10–15, and 8–9 when ACC_EN=0: result = 0.
- carry_flag = 0 for every op not listed above with a carry.
- zero_flag is computed from the registered result, in the same stage as result.
- Stage 1 (S1) registers operands, opcode and sel when in_valid && in_ready.
- Stage 2 (S2) computes the result and flags from S1 and registers them as the output bundle.
- The accumulator updates only on the cycle an ACC op moves S1→S2. An op stalled in S1 must never update it twice.
- Pipeline enables:
  - adv2 = S1_valid && (!out_valid || out_ready)
  - in_ready = !S1_valid || adv2
- No bubbles are inserted: sustained throughput is one bundle per clock with out_ready held high.
- The output bundle (result, flags, out_valid) stays stable while out_valid && !out_ready.

## Timing
- Latency: bundle accepted in cycle N → out_valid with its result in cycle N+2, if unstalled.
- Reset (rst high at an edge):
  - S1_valid = 0, out_valid = 0
  - result = 0, zero_flag = 1, carry_flag = 0
  - acc_value = 0, in_ready = 1 from the following cycle
- Reset mid-operation discards all in-flight bundles; nothing is emitted afterwards for them.
- Simultaneous out-transfer and S1→S2 advance in the same cycle is legal; the new bundle replaces the old with no gap.
- Back-to-back ACC ops see each other's results: the second one uses the accumulator value written by the first.
- in_valid deasserted: S1 drains; out_valid drops one cycle after the last transfer unless stalled.
- Ops are processed in order; bundle ordering is strictly FIFO through both stages.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD4, OP_ADD4_R, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SEL_SUM, OP_ACC_ADD, OP_ACC_CLR)
  - a typedef for the 4-bit opcode
- One sub-module: alu_core_comb. It is purely combinational (operands, opcode, sel, acc) → (result, carry, acc_next), and is parametrised by WIDTH.
- alu_pipe owns the stage registers, the handshake and the accumulator register.

## Test plan
- WIDTH=8, a=0x40, b=0x40, c=0x40, d=0x40, op 0, then the same operands with op 7 → both give result 0x00, zero=1, carry=1, two cycles after acceptance.
- SUB with a=0x03, b=0x05 → result 0xFE, carry=1, zero=0. SEL_SUM with sel=0, b=0x10, d=0xF0 → 0x00, zero=1, carry=1.
- ACC_CLR, then ACC_ADD a=0x80, then ACC_ADD a=0x81 → results 0x00, 0x80, 0x01 (carry=1); acc_value ends at 0x01.
- Stream 6 ops back-to-back with out_ready held low for 3 cycles after the first out_valid:
  - in_ready drops once S1 is full
  - the output bundle holds stable
  - all 6 results emerge in order, none lost or duplicated
  - an ACC op stalled in S1 updates the accumulator exactly once
- Assert rst while two bundles are in flight and acc=0x55 → next cycle out_valid=0, acc_value=0, result=0, zero=1; no stale bundle appears afterwards.
- Opcode 12 with nonzero operands → result 0, zero=1, carry=0. With ACC_EN=0, opcode 8 → result 0 and acc_value stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode type and opcode encodings for the pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_ADD4    = 4'd0;
    localparam opcode_t OP_SUB     = 4'd1;
    localparam opcode_t OP_AND     = 4'd2;
    localparam opcode_t OP_OR      = 4'd3;
    localparam opcode_t OP_XOR     = 4'd4;
    localparam opcode_t OP_NOT     = 4'd5;
    localparam opcode_t OP_SEL_SUM = 4'd6;
    localparam opcode_t OP_ADD4_R  = 4'd7;
    localparam opcode_t OP_ACC_ADD = 4'd8;
    localparam opcode_t OP_ACC_CLR = 4'd9;

endpackage
`default_nettype wire

// File: rtl/alu_core_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_core_comb
// Description : Purely combinational ALU datapath. Produces result, carry and
//               the next accumulator value from one operand bundle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core_comb
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [3:0]       opcode,
    input  logic             sel,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [WIDTH-1:0] acc_next
);

    logic [WIDTH+1:0] w_sum4;
    logic [WIDTH:0]   w_sel_sum;
    logic [WIDTH:0]   w_acc_sum;

    // Widened adders so the carry-outs are available directly.
    assign w_sum4    = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    assign w_sel_sum = sel ? ({1'b0, a} + {1'b0, c}) : ({1'b0, b} + {1'b0, d});
    assign w_acc_sum = {1'b0, acc} + {1'b0, a};

    // Opcode decode; accumulator holds its value for every non-ACC opcode.
    always_comb begin
        result   = '0;
        carry    = 1'b0;
        acc_next = acc;
        case (opcode)
            OP_ADD4, OP_ADD4_R: begin
                result = w_sum4[WIDTH-1:0];
                carry  = |w_sum4[WIDTH+1:WIDTH];
            end
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SEL_SUM: begin
                result = w_sel_sum[WIDTH-1:0];
                carry  = w_sel_sum[WIDTH];
            end
            OP_ACC_ADD: begin
                if (ACC_EN != 0) begin
                    result   = w_acc_sum[WIDTH-1:0];
                    carry    = w_acc_sum[WIDTH];
                    acc_next = w_acc_sum[WIDTH-1:0];
                end
            end
            OP_ACC_CLR: begin
                if (ACC_EN != 0) begin
                    acc_next = '0;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined four-operand ALU with valid/ready
//               handshake, full backpressure, flags and accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ACC_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] input_c,
    input  logic [WIDTH-1:0] input_d,
    input  logic [3:0]       opcode,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero_flag,
    output logic             carry_flag,
    output logic [WIDTH-1:0] acc_value
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [WIDTH-1:0] r_s1_c;
    logic [WIDTH-1:0] r_s1_d;
    logic [3:0]       r_s1_op;
    logic             r_s1_sel;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;

    logic             w_adv2;
    logic             w_accept;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic [WIDTH-1:0] w_acc_next;

    // S1 moves forward whenever the output slot is empty or being drained.
    assign w_adv2   = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready = !r_s1_valid || w_adv2;
    assign w_accept = in_valid && in_ready;

    alu_core_comb #(
        .WIDTH  (WIDTH),
        .ACC_EN (ACC_EN)
    ) u_core (
        .a        (r_s1_a),
        .b        (r_s1_b),
        .c        (r_s1_c),
        .d        (r_s1_d),
        .opcode   (r_s1_op),
        .sel      (r_s1_sel),
        .acc      (r_acc),
        .result   (w_result),
        .carry    (w_carry),
        .acc_next (w_acc_next)
    );

    // Stage 1: capture the operand bundle on an accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_d     <= '0;
            r_s1_op    <= '0;
            r_s1_sel   <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_a   <= input_a;
                r_s1_b   <= input_b;
                r_s1_c   <= input_c;
                r_s1_d   <= input_d;
                r_s1_op  <= opcode;
                r_s1_sel <= sel;
            end
        end
    end

    // Stage 2: register the computed bundle; hold it while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_carry     <= w_carry;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Accumulator commits only on the single cycle its op leaves S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_adv2) begin
            r_acc <= w_acc_next;
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign zero_flag  = (r_result == '0);
    assign carry_flag = r_carry;
    assign acc_value  = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Scoreboard testbench for alu_pipe (ACC_EN=1 and ACC_EN=0
//               instances driven in lockstep) against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 8;
    localparam int M = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] input_a = '0, input_b = '0, input_c = '0, input_d = '0;
    logic [3:0]   opcode = '0;
    logic         sel = 1'b0;
    logic         out_ready = 1'b1;

    logic         in_ready, out_valid, zero_flag, carry_flag;
    logic [W-1:0] result, acc_value;
    logic         in_ready_n, out_valid_n, zero_n, carry_n;
    logic [W-1:0] result_n, acc_n;

    alu_pipe #(.WIDTH(W), .ACC_EN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
        .opcode(opcode), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .acc_value(acc_value)
    );

    alu_pipe #(.WIDTH(W), .ACC_EN(0)) u_dut_noacc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
        .input_a(input_a), .input_b(input_b), .input_c(input_c), .input_d(input_d),
        .opcode(opcode), .sel(sel), .out_valid(out_valid_n), .out_ready(out_ready),
        .result(result_n), .zero_flag(zero_n), .carry_flag(carry_n),
        .acc_value(acc_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        int res1; bit cy1; int acc1;
        int res0; bit cy0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_acc1 = 0;
    int   m_acc0 = 0;
    bit   saw_block = 0;
    bit   hold_pending = 0;
    int   h_res; bit h_cy; bit h_zero;
    bit   done_rand;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: plain integer arithmetic on the opcode rules.
    function automatic void model(input int a, b, c, d, op, s, input bit acc_en,
                                  inout int acc, output int res, output bit cy);
        int sum;
        res = 0; cy = 0;
        case (op)
            0, 7: begin sum = a + b + c + d; res = sum % M; cy = (sum >= M); end
            1:    begin res = (a - b + M) % M; cy = (a < b); end
            2:    res = a & b;
            3:    res = a | b;
            4:    res = a ^ b;
            5:    res = (M - 1) - a;
            6:    begin sum = s ? (a + c) : (b + d); res = sum % M; cy = (sum >= M); end
            8:    if (acc_en) begin sum = acc + a; acc = sum % M; res = acc; cy = (sum >= M); end
            9:    if (acc_en) begin acc = 0; res = 0; end
            default: res = 0;
        endcase
    endfunction

    task automatic push_expected(input int a, b, c, d, op, s);
        exp_t e;
        model(a, b, c, d, op, s, 1'b1, m_acc1, e.res1, e.cy1);
        e.acc1 = m_acc1;
        model(a, b, c, d, op, s, 1'b0, m_acc0, e.res0, e.cy0);
        sb.push_back(e);
    endtask

    // Present one bundle and hold it until accepted (bounded).
    task automatic issue(input int a, b, c, d, op, s);
        int  n = 0;
        bit  ok;
        in_valid = 1'b1;
        input_a = W'(a); input_b = W'(b); input_c = W'(c); input_d = W'(d);
        opcode = 4'(op); sel = s[0];
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
            if (!ok) @(posedge clk);
        end while (!ok && n < 200);
        if (ok) push_expected(a, b, c, d, op, s);
        else chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output transfer; check hold stability.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_pending = 0;
        end else begin
            if (in_valid && !in_ready) saw_block = 1;
            if (hold_pending) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_result", result, h_res);
                chk("hold_carry", carry_flag, h_cy);
                chk("hold_zero", zero_flag, h_zero);
            end
            hold_pending = out_valid && !out_ready;
            h_res = result; h_cy = carry_flag; h_zero = zero_flag;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res1);
                    chk("zero", zero_flag, e.res1 == 0);
                    chk("carry", carry_flag, e.cy1);
                    chk("acc", acc_value, e.acc1);
                    chk("noacc_valid", out_valid_n, 1);
                    chk("noacc_ready", in_ready_n, in_ready);
                    chk("noacc_result", result_n, e.res0);
                    chk("noacc_zero", zero_n, e.res0 == 0);
                    chk("noacc_carry", carry_n, e.cy0);
                    chk("noacc_acc", acc_n, 0);
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero_flag, 1);
        chk("rst_carry", carry_flag, 0);
        chk("rst_acc", acc_value, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // ADD4 overflow, both encodings, with latency check
        issue(8'h40, 8'h40, 8'h40, 8'h40, 0, 0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_n1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_n2_valid", out_valid, 1);
        chk("add4_result", result, 8'h00);
        chk("add4_carry", carry_flag, 1);
        @(posedge clk); #1;
        issue(8'h40, 8'h40, 8'h40, 8'h40, 7, 0);
        idle(3);

        // SUB borrow and SEL_SUM wrap
        issue(8'h03, 8'h05, 0, 0, 1, 0);
        issue(8'h11, 8'h10, 8'h22, 8'hF0, 6, 0);
        issue(8'h12, 8'h34, 8'h56, 8'h78, 12, 1);
        idle(3);

        // Accumulator chain, back-to-back
        issue(0, 0, 0, 0, 9, 0);
        issue(8'h80, 0, 0, 0, 8, 0);
        issue(8'h81, 0, 0, 0, 8, 0);
        idle(4);
        chk("acc_final", acc_value, 8'h01);

        // Six-op stream with a three-cycle consumer stall
        saw_block = 0;
        fork
            begin
                issue(8'h01, 8'h02, 8'h03, 8'h04, 0, 0);
                issue(8'h05, 0, 0, 0, 8, 0);
                issue(8'h07, 0, 0, 0, 8, 0);
                issue(8'hA5, 8'h5A, 0, 0, 4, 0);
                issue(8'h0F, 0, 0, 0, 5, 0);
                issue(8'hF0, 8'h01, 8'h20, 8'h02, 6, 1);
                in_valid = 1'b0;
            end
            begin
                int n = 0;
                while (!out_valid && n < 50) begin @(negedge clk); n++; end
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(5);
        chk("stall_in_ready_dropped", saw_block, 1);

        // Reset with two bundles in flight and acc = 0x55
        issue(0, 0, 0, 0, 9, 0);
        issue(8'h55, 0, 0, 0, 8, 0);
        idle(4);
        chk("acc_pre_reset", acc_value, 8'h55);
        out_ready = 1'b0;
        issue(8'h01, 0, 0, 0, 8, 0);
        issue(8'h09, 8'h01, 0, 0, 1, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        m_acc1 = 0;
        m_acc0 = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_acc", acc_value, 0);
        chk("midrst_result", result, 0);
        chk("midrst_zero", zero_flag, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        idle(5);

        // Randomised traffic with random backpressure
        done_rand = 0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    issue($urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 255), $urandom_range(0, 255),
                          $urandom_range(0, 15), $urandom_range(0, 1));
                end
                in_valid = 1'b0;
                done_rand = 1;
            end
            begin
                while (!done_rand) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // Drain
        begin
            int n = 0;
            while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
        end
        idle(3);
        chk("drain_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
